integration_2_exec: RTL and testbench
=====================================

// Module: integration_2_exec
// PURPOSE
//  nanoQuarter (Minion CPU) execute/memory/writeback slice: 16-bit ALU, data-store RAM,
//  load/ALU result mux, register-write flag and next-PC computation. Sits after decode;
//  consumes decoded fields and register-file data, produces write-back data and the next PC.
//  ALU, mux and PC paths are combinational; only the store RAM is clocked.
// PARAMETERS
//  none (fixed widths: data 16, PC 32, RAM 64x16)
// PORTS
//  clk          in   1   system clock; one clock
//  rst          in   1   reset, asynchronous, active-low
//  reg1data_in  in   16  register source 1 data
//  reg2data_in  in   16  register source 2 data / store data
//  idata_in     in   8   immediate byte
//  jtarget_in   in   8   jump offset
//  memaddr_in   in   6   data RAM address
//  boffset_in   in   5   branch offset
//  funct_in     in   3   function code
//  op_in        in   2   00 R, 01 I, 10 J, 11 branch
//  shamt_in     in   2   post-shift amount (R-type)
//  bne_in       in   1   branch-not-equal flag
//  jr_in        in   1   reserved, ignored
//  jmp          in   1   jump flag
//  memread      in   1   select load data onto mmuxout
//  memwrite     in   1   store enable
//  PC_in        in   32  current PC
//  memdata      in   16  load data from memory system
//  PC_out       out  32  next PC
//  mmuxout      out  16  write-back data
//  regwrite     out  1   register-file write enable
// BEHAVIOUR
//  Internal ALUout[15:0] is combinational and exposed by that name for verification.
//  op=00, base result, then ALUout = (base << shamt_in) truncated to 16 bits:
//   000 NAND ~(r1&r2); 001 XOR; 010 SLL r1<<r2[3:0]; 011 SRL r1>>r2[3:0];
//   100 SRA r1>>>r2[3:0] (sign fill); 101 ADD r1+r2; 110 SUB r1-r2; 111 -> 0. Carries dropped.
//  op=01: 000 LUI / 010 SUI -> {idata,8'h00}; 001 LBI / 011 SBI -> {8'h00,idata};
//   1xx -> {10'b0,memaddr_in}. shamt_in ignored.
//  op=10/11: ALUout = 0.
//  mmuxout = memread ? memdata : ALUout.
//  regwrite = rst & (op==00 | (op==01 & funct<=001) | memread); 0 while rst low.
//  PC_out (unsigned, 32-bit wrap, offsets zero-extended), priority order:
//   jmp & funct==001 -> PC_in + reg1data_in (JR)
//   jmp (other funct) -> PC_in + jtarget_in (JMP)
//   bne_in & reg1!=reg2 -> PC_in + boffset_in
//   else -> PC_in + 2
//  PC_out and mmuxout are not affected by rst.
//  Store RAM mem[0:63] x16: posedge clk, memwrite & rst -> mem[memaddr_in] <= reg2data_in.
//   rst low clears all entries asynchronously; write during reset is dropped.
//  All outputs settle in the same cycle as inputs; zero latency, no handshake.
// TESTING
//  r1=080F,r2=80F9: op00 f000 sh01 -> ALUout=mmuxout=FFEC, regwrite=1; f001 sh11 -> 47B0.
//  r1=080F,r2=0001: SLL sh00 -> 101E; SRL/SRA -> 0407; ADD sh01 -> 1020; SUB sh11 -> 4070.
//  op01 idata=AA f000 -> AA00, regwrite=1; idata=88 f001 -> 0088; idata=81 f010 -> 8100,
//   regwrite=0; f011 -> 0081; memread=1, memdata=AFA0 -> mmuxout=AFA0.
//  PC_in=0: idle -> PC_out=2; jmp f000 jtarget=C0 -> C0; jmp f001 r1=7FFF -> 7FFF;
//   bne r1=7FFF r2=77FF boffset=0 -> 0; bne with r1==r2 -> 2.
//  memwrite=1 addr=05 r2=1234 at posedge -> mem[5]=1234; pulse rst low -> mem[5]=0000, regwrite=0.

Source files
------------

// File: rtl/integration_2_exec.sv
// Execute/memory/writeback slice: 16-bit ALU, 64x16 store RAM, load/ALU mux,
// register-write flag and next-PC selection. Everything but the RAM is combinational.
module integration_2_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] reg1data_in,
    input  logic [15:0] reg2data_in,
    input  logic [7:0]  idata_in,
    input  logic [7:0]  jtarget_in,
    input  logic [5:0]  memaddr_in,
    input  logic [4:0]  boffset_in,
    input  logic [2:0]  funct_in,
    input  logic [1:0]  op_in,
    input  logic [1:0]  shamt_in,
    input  logic        bne_in,
    input  logic        jr_in,
    input  logic        jmp,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] PC_in,
    input  logic [15:0] memdata,
    output logic [31:0] PC_out,
    output logic [15:0] mmuxout,
    output logic        regwrite
);

    localparam logic [1:0] OP_R = 2'b00;
    localparam logic [1:0] OP_I = 2'b01;

    logic [15:0] ALUout;
    logic [15:0] w_base;
    logic [3:0]  w_sh;
    logic        w_unused_jr;

    logic [15:0] mem [0:63];

    // jr_in is reserved; JR is decoded from jmp + funct instead.
    assign w_unused_jr = jr_in;
    assign w_sh        = reg2data_in[3:0];

    always_comb begin
        w_base = 16'h0000;
        ALUout = 16'h0000;
        case (op_in)
            OP_R: begin
                case (funct_in)
                    3'b000:  w_base = ~(reg1data_in & reg2data_in);
                    3'b001:  w_base = reg1data_in ^ reg2data_in;
                    3'b010:  w_base = reg1data_in << w_sh;
                    3'b011:  w_base = reg1data_in >> w_sh;
                    3'b100:  w_base = $unsigned($signed(reg1data_in) >>> w_sh);
                    3'b101:  w_base = reg1data_in + reg2data_in;
                    3'b110:  w_base = reg1data_in - reg2data_in;
                    default: w_base = 16'h0000;
                endcase
                ALUout = w_base << shamt_in;
            end
            OP_I: begin
                case (funct_in)
                    3'b000, 3'b010: ALUout = {idata_in, 8'h00};
                    3'b001, 3'b011: ALUout = {8'h00, idata_in};
                    default:        ALUout = {10'b0, memaddr_in};
                endcase
            end
            default: ALUout = 16'h0000;
        endcase
    end

    assign mmuxout  = memread ? memdata : ALUout;
    assign regwrite = rst & ((op_in == OP_R)
                           | ((op_in == OP_I) & (funct_in <= 3'b001))
                           | memread);

    // Offsets are unsigned displacements; sums wrap at 32 bits.
    always_comb begin
        if (jmp && funct_in == 3'b001)
            PC_out = PC_in + {16'h0000, reg1data_in};
        else if (jmp)
            PC_out = PC_in + {24'h000000, jtarget_in};
        else if (bne_in && (reg1data_in != reg2data_in))
            PC_out = PC_in + {27'h0000000, boffset_in};
        else
            PC_out = PC_in + 32'd2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= 16'h0000;
        end else if (memwrite) begin
            mem[memaddr_in] <= reg2data_in;
        end
    end

endmodule

// File: tb/tb_integration_2_exec.sv
// Directed bench for the execute slice: ALU ops, immediates, mux, regwrite, next-PC, store RAM.
module tb_integration_2_exec;

    logic        clk;
    logic        rst;
    logic [15:0] reg1data_in, reg2data_in, memdata, mmuxout;
    logic [7:0]  idata_in, jtarget_in;
    logic [5:0]  memaddr_in;
    logic [4:0]  boffset_in;
    logic [2:0]  funct_in;
    logic [1:0]  op_in, shamt_in;
    logic        bne_in, jr_in, jmp, memread, memwrite, regwrite;
    logic [31:0] PC_in, PC_out;

    int checks   = 0;
    int failures = 0;

    integration_2_exec dut (
        .clk(clk), .rst(rst),
        .reg1data_in(reg1data_in), .reg2data_in(reg2data_in),
        .idata_in(idata_in), .jtarget_in(jtarget_in),
        .memaddr_in(memaddr_in), .boffset_in(boffset_in),
        .funct_in(funct_in), .op_in(op_in), .shamt_in(shamt_in),
        .bne_in(bne_in), .jr_in(jr_in), .jmp(jmp),
        .memread(memread), .memwrite(memwrite),
        .PC_in(PC_in), .memdata(memdata),
        .PC_out(PC_out), .mmuxout(mmuxout), .regwrite(regwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic alu(input logic [1:0] op, input logic [2:0] f, input logic [1:0] sh,
                       input logic [15:0] r1, input logic [15:0] r2);
        @(negedge clk);
        op_in = op; funct_in = f; shamt_in = sh;
        reg1data_in = r1; reg2data_in = r2;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        reg1data_in = '0; reg2data_in = '0; memdata = '0;
        idata_in = '0; jtarget_in = '0; memaddr_in = '0; boffset_in = '0;
        funct_in = '0; op_in = '0; shamt_in = '0;
        bne_in = 0; jr_in = 0; jmp = 0; memread = 0; memwrite = 0; PC_in = '0;
        #2;
        check("reset_regwrite", {31'b0, regwrite}, 32'h0);
        check("reset_mem5", {16'h0, dut.mem[5]}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // R-type ALU
        alu(2'b00, 3'b000, 2'b01, 16'h080F, 16'h80F9);
        check("nand_alu", {16'h0, dut.ALUout}, 32'hFFEC);
        check("nand_mux", {16'h0, mmuxout}, 32'hFFEC);
        check("nand_regwrite", {31'b0, regwrite}, 32'h1);
        alu(2'b00, 3'b001, 2'b11, 16'h080F, 16'h80F9);
        check("xor_sh3", {16'h0, mmuxout}, 32'h47B0);
        alu(2'b00, 3'b010, 2'b00, 16'h080F, 16'h0001);
        check("sll", {16'h0, mmuxout}, 32'h101E);
        alu(2'b00, 3'b011, 2'b00, 16'h080F, 16'h0001);
        check("srl", {16'h0, mmuxout}, 32'h0407);
        alu(2'b00, 3'b100, 2'b00, 16'h080F, 16'h0001);
        check("sra_pos", {16'h0, mmuxout}, 32'h0407);
        alu(2'b00, 3'b101, 2'b01, 16'h080F, 16'h0001);
        check("add_sh1", {16'h0, mmuxout}, 32'h1020);
        alu(2'b00, 3'b110, 2'b11, 16'h080F, 16'h0001);
        check("sub_sh3", {16'h0, mmuxout}, 32'h4070);
        alu(2'b00, 3'b100, 2'b00, 16'h8000, 16'h0004);
        check("sra_neg", {16'h0, mmuxout}, 32'hF800);
        alu(2'b00, 3'b011, 2'b00, 16'h8000, 16'h0004);
        check("srl_neg", {16'h0, mmuxout}, 32'h0800);
        alu(2'b00, 3'b101, 2'b00, 16'hFFFF, 16'h0002);
        check("add_wrap", {16'h0, mmuxout}, 32'h0001);
        alu(2'b00, 3'b111, 2'b00, 16'h1234, 16'h5678);
        check("f111_zero", {16'h0, mmuxout}, 32'h0000);

        // I-type
        idata_in = 8'hAA;
        alu(2'b01, 3'b000, 2'b11, 16'h0, 16'h0);
        check("lui", {16'h0, mmuxout}, 32'hAA00);
        check("lui_regwrite", {31'b0, regwrite}, 32'h1);
        idata_in = 8'h88;
        alu(2'b01, 3'b001, 2'b00, 16'h0, 16'h0);
        check("lbi", {16'h0, mmuxout}, 32'h0088);
        idata_in = 8'h81;
        alu(2'b01, 3'b010, 2'b00, 16'h0, 16'h0);
        check("sui", {16'h0, mmuxout}, 32'h8100);
        check("sui_regwrite", {31'b0, regwrite}, 32'h0);
        alu(2'b01, 3'b011, 2'b00, 16'h0, 16'h0);
        check("sbi", {16'h0, mmuxout}, 32'h0081);
        memaddr_in = 6'h2D;
        alu(2'b01, 3'b110, 2'b00, 16'h0, 16'h0);
        check("i_memaddr", {16'h0, mmuxout}, 32'h002D);
        check("i1xx_regwrite", {31'b0, regwrite}, 32'h0);
        memread = 1'b1; memdata = 16'hAFA0; #1;
        check("load_mux", {16'h0, mmuxout}, 32'hAFA0);
        check("load_regwrite", {31'b0, regwrite}, 32'h1);
        memread = 1'b0;
        alu(2'b10, 3'b000, 2'b00, 16'hFFFF, 16'hFFFF);
        check("op10_zero", {16'h0, mmuxout}, 32'h0000);
        check("op10_regwrite", {31'b0, regwrite}, 32'h0);

        // Next PC
        alu(2'b11, 3'b000, 2'b00, 16'h0, 16'h0);
        PC_in = 32'h0; #1;
        check("pc_idle", PC_out, 32'h2);
        jmp = 1'b1; jtarget_in = 8'hC0; #1;
        check("pc_jmp", PC_out, 32'hC0);
        funct_in = 3'b001; reg1data_in = 16'h7FFF; #1;
        check("pc_jr", PC_out, 32'h7FFF);
        jmp = 1'b0; bne_in = 1'b1; reg2data_in = 16'h77FF; boffset_in = 5'd0; #1;
        check("pc_bne_taken0", PC_out, 32'h0);
        boffset_in = 5'h1F; PC_in = 32'h100; #1;
        check("pc_bne_off", PC_out, 32'h11F);
        reg2data_in = 16'h7FFF; #1;
        check("pc_bne_equal", PC_out, 32'h102);
        jmp = 1'b1; #1;
        check("pc_jr_prio", PC_out, 32'h80FF);
        jmp = 1'b0; bne_in = 1'b0; PC_in = 32'hFFFF_FFFF; #1;
        check("pc_wrap", PC_out, 32'h1);

        // Store RAM
        @(negedge clk);
        memwrite = 1'b1; memaddr_in = 6'd5; reg2data_in = 16'h1234;
        @(negedge clk);
        memwrite = 1'b0;
        check("mem5_write", {16'h0, dut.mem[5]}, 32'h1234);
        rst = 1'b0; #1;
        check("mem5_cleared", {16'h0, dut.mem[5]}, 32'h0);
        check("rst_regwrite", {31'b0, regwrite}, 32'h0);
        memwrite = 1'b1; memaddr_in = 6'd6; reg2data_in = 16'h5555;
        @(negedge clk);
        check("mem6_rst_drop", {16'h0, dut.mem[6]}, 32'h0);
        memwrite = 1'b0; rst = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
